stat_counter_bank: RTL and testbench

Parametrised execution-statistics unit that replaces the fixed unconditional/conditional/taken-branch counters feeding the seven-segment display path. It holds NUM_CH event counters of CNT_WIDTH bits, with selectable saturate/wrap mode and sticky overflow flags. A syscall-driven halt state stops counting, and a snapshot shadow bank gives the display a stable copy while the CPU keeps running. It sits beside the NPC, clocked on the CPU run clock, and feeds the display multiplexer through a registered read port.

---
 rtl/stat_counter_bank_if.sv | 25 ++
 rtl/stat_counter_bank.sv | 57 +++++
 tb/tb_stat_counter_bank.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/stat_counter_bank_if.sv
// stat_counter_bank_if: event/control inputs and read-port outputs of the statistics counter bank
interface stat_counter_bank_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int SEL_WIDTH = 2
);
  logic                 step_en;
  logic [NUM_CH-1:0]    event_in;
  logic                 halt_in;
  logic                 clear;
  logic                 snap;
  logic                 rd_live;
  logic [SEL_WIDTH-1:0] rd_sel;
  logic [CNT_WIDTH-1:0] rd_data;
  logic [NUM_CH-1:0]    ovf;
  logic                 halted;
  modport master (
    output step_en, event_in, halt_in, clear, snap, rd_live, rd_sel,
    input  rd_data, ovf, halted
  );
  modport slave (
    input  step_en, event_in, halt_in, clear, snap, rd_live, rd_sel,
    output rd_data, ovf, halted
  );
endinterface

// File: rtl/stat_counter_bank.sv
// stat_counter_bank: per-channel event counters with halt state, sticky overflow, snapshot bank and registered read
module stat_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int SEL_WIDTH = 2,
  parameter int SATURATE  = 1
) (
  input logic clk,
  input logic rst,
  stat_counter_bank_if.slave bus
);
  typedef enum logic {RUN, HALTED} state_t;
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_nx [NUM_CH];
  logic [CNT_WIDTH-1:0] shadow [NUM_CH];
  logic [CNT_WIDTH-1:0] shadow_nx [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_nx;
  logic [CNT_WIDTH-1:0] rd_q, rd_nx;
  logic count_en, snap_en;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= state_nx;
  always_comb begin
    count_en = state == RUN && bus.step_en && !bus.clear;
    snap_en = bus.step_en && bus.snap && !bus.clear;
    state_nx = bus.clear ? RUN : (count_en && bus.halt_in) ? HALTED : state;
    ovf_nx = bus.clear ? '0 : ovf_q;
    rd_nx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_nx[i] = snap_en ? cnt[i] : shadow[i];
      cnt_nx[i] = bus.clear ? '0 : cnt[i];
      if (count_en && bus.event_in[i]) begin
        cnt_nx[i] = cnt[i] != MAX ? cnt[i] + 1'b1 : (SATURATE != 0 ? MAX : '0);
        ovf_nx[i] = ovf_q[i] | (cnt[i] == MAX);
      end
      // out-of-range selects match no channel and leave rd_nx at zero
      if (bus.rd_sel == SEL_WIDTH'(i)) rd_nx = bus.rd_live ? cnt[i] : shadow[i];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '{default: '0};
      shadow <= '{default: '0};
      ovf_q <= '0;
      rd_q <= '0;
    end else begin
      cnt <= cnt_nx;
      shadow <= shadow_nx;
      ovf_q <= ovf_nx;
      rd_q <= rd_nx;
    end
  assign bus.rd_data = rd_q;
  assign bus.ovf = ovf_q;
  assign bus.halted = state == HALTED;
endmodule

// File: tb/tb_stat_counter_bank.sv
// tb_stat_counter_bank: saturating and wrapping instances checked against a behavioural model every cycle
module tb_stat_counter_bank;
  localparam int N = 3;
  localparam int W = 4;
  localparam int S = 2;
  localparam int MAXV = (1 << W) - 1;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic step_en = 0, halt_in = 0, clear = 0, snap = 0, rd_live = 0;
  logic [N-1:0] event_in = '0;
  logic [S-1:0] rd_sel = '0;
  int n_cmp = 0, n_err = 0;
  stat_counter_bank_if #(.NUM_CH(N), .CNT_WIDTH(W), .SEL_WIDTH(S)) bs ();
  stat_counter_bank_if #(.NUM_CH(N), .CNT_WIDTH(W), .SEL_WIDTH(S)) bw ();
  assign bs.step_en = step_en;   assign bw.step_en = step_en;
  assign bs.event_in = event_in; assign bw.event_in = event_in;
  assign bs.halt_in = halt_in;   assign bw.halt_in = halt_in;
  assign bs.clear = clear;       assign bw.clear = clear;
  assign bs.snap = snap;         assign bw.snap = snap;
  assign bs.rd_live = rd_live;   assign bw.rd_live = rd_live;
  assign bs.rd_sel = rd_sel;     assign bw.rd_sel = rd_sel;
  stat_counter_bank #(.NUM_CH(N), .CNT_WIDTH(W), .SEL_WIDTH(S), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .bus(bs.slave));
  stat_counter_bank #(.NUM_CH(N), .CNT_WIDTH(W), .SEL_WIDTH(S), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .bus(bw.slave));
  // model: index 0 = saturating instance, 1 = wrapping instance
  int m_cnt [2][N];
  int m_sh [2][N];
  bit m_ovf [2][N];
  bit m_halt [2];
  int m_rd [2];
  always @(posedge clk or negedge rst)
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_halt[d] = 0;
        m_rd[d] = 0;
        for (int k = 0; k < N; k++) begin
          m_cnt[d][k] = 0;
          m_sh[d][k] = 0;
          m_ovf[d][k] = 0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_rd[d] = int'(rd_sel) < N ? (rd_live ? m_cnt[d][rd_sel] : m_sh[d][rd_sel]) : 0;
        if (clear) begin
          m_halt[d] = 0;
          for (int k = 0; k < N; k++) begin
            m_cnt[d][k] = 0;
            m_ovf[d][k] = 0;
          end
        end else if (step_en) begin
          if (snap) for (int k = 0; k < N; k++) m_sh[d][k] = m_cnt[d][k];
          if (!m_halt[d]) begin
            for (int k = 0; k < N; k++)
              if (event_in[k]) begin
                if (m_cnt[d][k] == MAXV) m_ovf[d][k] = 1;
                m_cnt[d][k] = d == 0 ? (m_cnt[d][k] + 1 > MAXV ? MAXV : m_cnt[d][k] + 1)
                                     : (m_cnt[d][k] + 1) % (MAXV + 1);
              end
            if (halt_in) m_halt[d] = 1;
          end
        end
      end
    end
  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  function automatic int exp_ovf(input int d);
    int v = 0;
    for (int k = 0; k < N; k++) v |= int'(m_ovf[d][k]) << k;
    return v;
  endfunction
  always @(posedge clk) begin
    #1;
    chk("cyc rd_data sat", int'(bs.rd_data), m_rd[0]);
    chk("cyc rd_data wrap", int'(bw.rd_data), m_rd[1]);
    chk("cyc ovf sat", int'(bs.ovf), exp_ovf(0));
    chk("cyc ovf wrap", int'(bw.ovf), exp_ovf(1));
    chk("cyc halted sat", int'(bs.halted), int'(m_halt[0]));
    chk("cyc halted wrap", int'(bw.halted), int'(m_halt[1]));
  end
  task automatic cyc(input logic [N-1:0] ev, input bit st, input bit h, input bit sn, input bit cl);
    @(negedge clk);
    event_in = ev; step_en = st; halt_in = h; snap = sn; clear = cl;
    @(posedge clk);
    #2;
  endtask
  task automatic rd(input bit live, input int sel, input string nm, input int es, input int ew);
    rd_live = live;
    rd_sel = S'(sel);
    cyc('0, 0, 0, 0, 0);
    chk({nm, " sat"}, int'(bs.rd_data), es);
    chk({nm, " wrap"}, int'(bw.rd_data), ew);
  endtask
  initial begin
    #1 rst = 0;
    #2;
    chk("reset rd_data", int'(bs.rd_data), 0);
    chk("reset halted", int'(bs.halted), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    repeat (10) cyc(3'b101, 1, 0, 0, 0);
    rd(1, 0, "ch0 ten", 10, 10);
    rd(1, 2, "ch2 ten", 10, 10);
    rd(1, 1, "ch1 zero", 0, 0);
    chk("ovf none", int'(bs.ovf), 0);
    cyc('0, 0, 0, 0, 1);
    repeat (17) cyc(3'b010, 1, 0, 0, 0);
    rd(1, 1, "ch1 overflow", 15, 1);
    chk("ovf1 sat", int'(bs.ovf), 2);
    chk("ovf1 wrap", int'(bw.ovf), 2);
    cyc('0, 0, 0, 0, 1);
    repeat (5) cyc(3'b001, 1, 0, 0, 0);
    cyc(3'b001, 1, 1, 0, 0);
    chk("halt entered", int'(bs.halted), 1);
    repeat (3) cyc(3'b001, 1, 1, 0, 0);
    rd(1, 0, "halted ch0", 6, 6);
    cyc('0, 0, 0, 0, 1);
    chk("halt cleared", int'(bw.halted), 0);
    rd(1, 0, "cleared ch0", 0, 0);
    repeat (7) cyc(3'b100, 1, 0, 0, 0);
    cyc(3'b100, 1, 0, 1, 0);
    rd(0, 2, "shadow ch2", 7, 7);
    rd(1, 2, "live ch2", 8, 8);
    cyc(3'b111, 1, 0, 1, 1);
    rd(1, 2, "clear live ch2", 0, 0);
    rd(0, 2, "clear shadow ch2", 7, 7);
    rd(1, 3, "sel out of range", 0, 0);
    repeat (17) cyc(3'b010, 1, 0, 0, 0);
    cyc('0, 1, 1, 0, 0);
    rd(1, 1, "pre-reset ch1", 15, 1);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("async rd_data", int'(bs.rd_data), 0);
    chk("async ovf", int'(bs.ovf) | int'(bw.ovf), 0);
    chk("async halted", int'(bs.halted) | int'(bw.halted), 0);
    @(negedge clk) rst = 1;
    repeat (3) cyc(3'b001, 1, 0, 0, 0);
    rd(1, 0, "resume ch0", 3, 3);
    repeat (3000) begin
      rd_live = 1'($urandom_range(0, 1));
      rd_sel = S'($urandom_range(0, 3));
      cyc(N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
